sprite_rom_arbiter: RTL
=======================

Name: sprite_rom_arbiter

Overview:
- Shares one single-port sprite/palette-index ROM among NUM_REQ pixel requesters, e.g. title screen, background, player and enemy layers.
- Arbitration is round-robin, one grant per vga_clk cycle.
- Tracks in-flight reads through a tag pipeline matching the ROM latency and returns each result only to the requester that issued it.
- Sits between the per-layer address generators and the ROM instance, which is clocked on negedge vga_clk.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 14, ROM address width.
- DATA_W, 2, ROM word width (palette index).
- ROM_LAT, 1, posedge cycles from rom_address registered to rom_q valid at the next posedge (the negedge ROM gives 1).

Ports:
- vga_clk  in  1  pixel clock; all logic is on posedge.
- reset_n  in  1  synchronous active-low reset.
- req  in  NUM_REQ  per-requester read request.
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; slice i is [i*ADDR_W +: ADDR_W].
- gnt  out  NUM_REQ  one-hot grant, combinational in the request cycle.
- rom_address  out  ADDR_W  registered ROM address.
- rom_q  in  DATA_W  ROM read data.
- rsp_valid  out  NUM_REQ  one-hot response strobe, registered.
- rsp_data  out  DATA_W  registered read data, qualified by rsp_valid.
- busy  out  1  high while any read is in flight.

Behaviour:
- Reset:
  - Synchronous, active-low, sampled on posedge vga_clk.
  - While reset_n = 0, gnt is forced to 0.
  - At the first posedge with reset_n = 0: rom_address = 0, rsp_valid = 0, rsp_data = 0, busy = 0, rr_ptr = 0, tag pipeline cleared.
- Arbitration (cycle t):
  - Search req starting at index rr_ptr, wrapping modulo NUM_REQ.
  - The first set bit k gets gnt[k] = 1. At most one gnt bit is high.
- Handshake:
  - A requester holds req and its req_addr stable until it sees gnt.
  - It may deassert req before gnt; that costs nothing.
  - A request is consumed in a cycle where req[k] and gnt[k] are both high.
  - To issue back-to-back reads, the requester keeps req high and changes req_addr after each grant.
- On the posedge ending cycle t with a grant to k:
  - rom_address <= req_addr[k].
  - Tag stage 0 <= {valid = 1, id = k}.
  - rr_ptr <= (k + 1) mod NUM_REQ.
- With no grant:
  - rom_address holds its value and rr_ptr holds.
  - Tag stage 0 valid <= 0.
- Tag pipeline:
  - ROM_LAT stages of {valid, id}, shifting every cycle with no stall.
  - At the posedge where the last stage is valid with id = k: rsp_valid <= one-hot(k), rsp_data <= rom_q.
  - Otherwise rsp_valid <= 0 and rsp_data holds.
- Latency: grant in cycle t gives rsp_valid in cycle t + 1 + ROM_LAT (t + 2 at the default).
- Throughput: 1 read per cycle. The pipeline never backpressures and requesters must accept responses.
- busy = OR of all tag-stage valid bits.
- Fairness: with all requests held high, grants rotate 0, 1, 2, 3, 0, ... and no requester waits more than NUM_REQ − 1 cycles.
- Reset mid-operation: in-flight reads are discarded, no rsp_valid is produced for them, and rr_ptr returns to 0.
- Response and new grant to the same requester in the same cycle: both occur independently.
- rr_ptr wraps from NUM_REQ − 1 to 0.
- Width rules:
  - rr_ptr and id are $clog2(NUM_REQ) bits.
  - Modulo is implemented as a wrap compare, not a divide.

Optional Feature:
- Macro: SPRITE_ARB_PRIO0_EN.
- Defined:
  - Requester 0 (the display-critical layer) wins whenever req[0] = 1, regardless of rr_ptr.
  - Its grants do not update rr_ptr.
  - The remaining requesters round-robin among themselves.
- Undefined: pure round-robin across all requesters, as specified above.

Decomposition:
- Package sprite_arb_pkg holds:
  - localparam defaults (NUM_REQ, ADDR_W, DATA_W, ROM_LAT).
  - typedef struct packed {logic valid; logic [ID_W-1:0] id;} rom_tag_t.
  - A function onehot_from_id.
- One sub-module, rr_pick:
  - Purely combinational round-robin priority encoder.
  - Inputs: req, rr_ptr. Outputs: gnt, gnt_id, any_gnt.
  - Reused by other shared-resource arbiters in the design.

Test Plan:
- Reset then idle: reset_n = 0 for 2 cycles, then req = 0 → gnt = 0, rsp_valid = 0, rom_address = 0, busy = 0.
- Single read: req = 4'b0100, req_addr[2] = 14'd300, ROM word 300 = 2'b10 → gnt = 4'b0100 in cycle t; rsp_valid = 4'b0100 and rsp_data = 2'b10 in cycle t+2.
- Full contention: req = 4'b1111 held for 8 cycles with distinct addresses → grant order 0,1,2,3,0,1,2,3; responses arrive in the same order, each 2 cycles after its grant.
- Rotation with gaps: req = 4'b1010 held → grants alternate 1,3,1,3; rr_ptr wraps from 3 to 0 and then picks 1.
- Reset mid-flight: grant to requester 1, then assert reset_n = 0 in cycle t+1 → no rsp_valid follows; after release, req = 4'b1111 is granted to 0 first.
- SPRITE_ARB_PRIO0_EN defined: req = 4'b1111 held → requester 0 is granted every cycle; with req[0] dropped, grants cycle 1,2,3.

Source files
------------

// File: rtl/sprite_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sprite_arb_pkg
// Description : Shared defaults, in-flight read tag type and one-hot helper
//               for the sprite ROM arbiter and its round-robin picker.
// Revision    : 1.0 - initial release
// ============================================================================
package sprite_arb_pkg;

    localparam int NUM_REQ_DEFAULT = 4;
    localparam int ADDR_W_DEFAULT  = 14;
    localparam int DATA_W_DEFAULT  = 2;
    localparam int ROM_LAT_DEFAULT = 1;

    // Tag id is sized for the largest supported requester count (8).
    localparam int MAX_REQ = 8;
    localparam int ID_W    = $clog2(MAX_REQ);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } rom_tag_t;

    function automatic logic [MAX_REQ-1:0] onehot_from_id(input logic [ID_W-1:0] id);
        return MAX_REQ'(1) << id;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_rom_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin priority encoder; searches req
//               from rr_ptr upward, wrapping at NUM_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   gnt_id,
    output logic               any_gnt
);

    logic [PTR_W:0] w_idx;

    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        any_gnt = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // One extra bit holds rr_ptr + i before the wrap compare.
            w_idx = {1'b0, rr_ptr} + (PTR_W+1)'(i);
            if (w_idx >= (PTR_W+1)'(NUM_REQ)) begin
                w_idx = w_idx - (PTR_W+1)'(NUM_REQ);
            end
            if (!any_gnt && req[w_idx[PTR_W-1:0]]) begin
                any_gnt = 1'b1;
                gnt_id  = w_idx[PTR_W-1:0];
            end
        end
        gnt[gnt_id] = any_gnt;
    end

endmodule
`default_nettype wire

// File: rtl/sprite_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sprite_rom_arbiter
// Description : Round-robin sharing of one negedge sprite ROM among NUM_REQ
//               pixel layers, with a tag pipeline routing each result back.
//               Optional macro SPRITE_ARB_PRIO0_EN gives requester 0 absolute
//               priority.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_rom_arbiter
    import sprite_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEFAULT,
    parameter int ADDR_W  = ADDR_W_DEFAULT,
    parameter int DATA_W  = DATA_W_DEFAULT,
    parameter int ROM_LAT = ROM_LAT_DEFAULT
) (
    input  logic                      vga_clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         rom_address,
    input  logic [DATA_W-1:0]         rom_q,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      busy
);

    localparam int c_ptr_w = $clog2(NUM_REQ);

    logic [ADDR_W-1:0]  w_addr [NUM_REQ];
    logic [NUM_REQ-1:0] w_rr_req;
    logic [NUM_REQ-1:0] w_rr_gnt;
    logic [c_ptr_w-1:0] w_rr_id;
    logic               w_rr_any;
    logic [NUM_REQ-1:0] w_gnt;
    logic [c_ptr_w-1:0] w_gnt_id;
    logic               w_gnt_any;
    logic               w_ptr_adv;
    logic [c_ptr_w-1:0] w_next_ptr;
    logic [MAX_REQ-1:0] w_rsp_full;
    logic [NUM_REQ-1:0] w_rsp_onehot;
    logic               w_busy;

    logic [c_ptr_w-1:0] r_rr_ptr;
    logic [ADDR_W-1:0]  r_rom_address;
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [DATA_W-1:0]  r_rsp_data;
    rom_tag_t           r_tag [ROM_LAT];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_addr_unpack
        assign w_addr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (c_ptr_w)
    ) u_rr_pick (
        .req     (w_rr_req),
        .rr_ptr  (r_rr_ptr),
        .gnt     (w_rr_gnt),
        .gnt_id  (w_rr_id),
        .any_gnt (w_rr_any)
    );

`ifdef SPRITE_ARB_PRIO0_EN
    // Requester 0 bypasses the rotation and leaves rr_ptr untouched.
    assign w_rr_req = {req[NUM_REQ-1:1], 1'b0};

    always_comb begin
        w_gnt     = w_rr_gnt;
        w_gnt_id  = w_rr_id;
        w_gnt_any = w_rr_any;
        w_ptr_adv = w_rr_any;
        if (req[0]) begin
            w_gnt     = NUM_REQ'(1);
            w_gnt_id  = '0;
            w_gnt_any = 1'b1;
            w_ptr_adv = 1'b0;
        end
    end
`else
    assign w_rr_req  = req;
    assign w_gnt     = w_rr_gnt;
    assign w_gnt_id  = w_rr_id;
    assign w_gnt_any = w_rr_any;
    assign w_ptr_adv = w_rr_any;
`endif

    assign w_next_ptr = (w_gnt_id == c_ptr_w'(NUM_REQ - 1)) ? '0 : w_gnt_id + c_ptr_w'(1);

    assign w_rsp_full   = onehot_from_id(r_tag[ROM_LAT-1].id);
    assign w_rsp_onehot = w_rsp_full[NUM_REQ-1:0];

    if (NUM_REQ < MAX_REQ) begin : g_unused_hi
        logic w_unused_onehot_hi;
        assign w_unused_onehot_hi = |w_rsp_full[MAX_REQ-1:NUM_REQ];
    end

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            r_rom_address <= '0;
            r_rr_ptr      <= '0;
            r_rsp_valid   <= '0;
            r_rsp_data    <= '0;
            for (int s = 0; s < ROM_LAT; s++) begin
                r_tag[s] <= '0;
            end
        end else begin
            if (w_gnt_any) begin
                r_rom_address <= w_addr[w_gnt_id];
            end
            if (w_ptr_adv) begin
                r_rr_ptr <= w_next_ptr;
            end
            r_tag[0] <= '{valid: w_gnt_any, id: ID_W'(w_gnt_id)};
            for (int s = 1; s < ROM_LAT; s++) begin
                r_tag[s] <= r_tag[s-1];
            end
            // rom_q is valid here for the read tagged in the last stage.
            if (r_tag[ROM_LAT-1].valid) begin
                r_rsp_valid <= w_rsp_onehot;
                r_rsp_data  <= rom_q;
            end else begin
                r_rsp_valid <= '0;
            end
        end
    end

    always_comb begin
        w_busy = 1'b0;
        for (int s = 0; s < ROM_LAT; s++) begin
            w_busy = w_busy | r_tag[s].valid;
        end
    end

    assign gnt         = reset_n ? w_gnt : '0;
    assign rom_address = r_rom_address;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign busy        = w_busy;

endmodule
`default_nettype wire
